// File: rtl/lfsr_rng.sv
// Galois LFSR random-number generator with range-limited draws.
// Draws use rejection sampling and fall back to 0 after MAX_TRIES rejections.
module lfsr_rng #(
  parameter int               WIDTH        = 16,
  parameter int               OUT_W        = 9,
  parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1,
  parameter int               MAX_TRIES    = 16
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [OUT_W-1:0] limit,
  input  logic             req,
  output logic             busy,
  output logic             out_valid,
  output logic [OUT_W-1:0] out,
  output logic             out_fallback,
  output logic             seed_fix,
  output logic [WIDTH-1:0] state_out
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  // Handshake: req is sampled only in ST_IDLE; each accepted req produces exactly
  // one single-cycle out_valid (out/out_fallback qualified by it) unless a
  // seed_load or reset aborts the draw, in which case no out_valid is produced.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DRAW = 1'b1
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [TRY_W-1:0] try_q, try_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             fallback_q, fallback_d;
  logic             seed_fix_q, seed_fix_d;

  logic [WIDTH-1:0] step_val;
  logic [OUT_W-1:0] candidate;
  logic             accept;
  logic [TRY_W-1:0] try_inc;

  // A computed zero state is replaced by DEFAULT_SEED so the LFSR can never lock up.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ TAPS;
    if (n == '0) n = DEFAULT_SEED;
    return n;
  endfunction

  always_comb begin
    step_val  = lfsr_step(lfsr_q);
    candidate = lfsr_q[OUT_W-1:0];
    accept    = (limit == '0) || (candidate < limit);
    try_inc   = try_q + TRY_W'(1);
  end

  always_comb begin
    fsm_d       = fsm_q;
    lfsr_d      = lfsr_q;
    try_d       = try_q;
    out_d       = out_q;
    fallback_d  = fallback_q;
    out_valid_d = 1'b0;
    seed_fix_d  = 1'b0;

    if (seed_load) begin
      lfsr_d     = (seed == '0) ? DEFAULT_SEED : seed;
      seed_fix_d = (seed == '0);
      fsm_d      = ST_IDLE;
      try_d      = '0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (req) begin
            fsm_d = ST_DRAW;
            try_d = '0;
          end else if (enable) begin
            lfsr_d = step_val;
          end
        end
        ST_DRAW: begin
          lfsr_d = step_val;
          if (accept) begin
            out_d       = candidate;
            fallback_d  = 1'b0;
            out_valid_d = 1'b1;
            fsm_d       = ST_IDLE;
          end else if (try_inc == TRY_W'(MAX_TRIES)) begin
            out_d       = '0;
            fallback_d  = 1'b1;
            out_valid_d = 1'b1;
            fsm_d       = ST_IDLE;
            try_d       = try_inc;
          end else begin
            try_d = try_inc;
          end
        end
        default: fsm_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      fsm_q       <= ST_IDLE;
      lfsr_q      <= DEFAULT_SEED;
      try_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      fallback_q  <= 1'b0;
      seed_fix_q  <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      lfsr_q      <= lfsr_d;
      try_q       <= try_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      fallback_q  <= fallback_d;
      seed_fix_q  <= seed_fix_d;
    end
  end

  assign busy         = (fsm_q == ST_DRAW);
  assign out_valid    = out_valid_q;
  assign out          = out_q;
  assign out_fallback = fallback_q;
  assign seed_fix     = seed_fix_q;
  assign state_out    = lfsr_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Bench for lfsr_rng: default instance plus a MAX_TRIES=4 instance sharing stimulus;
// draw results are checked by scoreboard monitors against hand-computed vectors.
module tb_lfsr_rng;

  localparam int OUT_W = 9;
  localparam int EW    = 32 + 1 + OUT_W;

  logic             Clk = 1'b0;
  logic             reset, enable, seed_load, req;
  logic [15:0]      seed;
  logic [OUT_W-1:0] limit;

  logic             busy, out_valid, out_fallback, seed_fix;
  logic [OUT_W-1:0] out;
  logic [15:0]      state_out;
  logic             busy_4, out_valid_4, out_fallback_4, seed_fix_4;
  logic [OUT_W-1:0] out_4;
  logic [15:0]      state_out_4;

  lfsr_rng dut (
    .Clk(Clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed(seed),
    .limit(limit), .req(req), .busy(busy), .out_valid(out_valid), .out(out),
    .out_fallback(out_fallback), .seed_fix(seed_fix), .state_out(state_out)
  );

  lfsr_rng #(.MAX_TRIES(4)) dut4 (
    .Clk(Clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed(seed),
    .limit(limit), .req(req), .busy(busy_4), .out_valid(out_valid_4), .out(out_4),
    .out_fallback(out_fallback_4), .seed_fix(seed_fix_4), .state_out(state_out_4)
  );

  // Clock / reset block
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp4_q[$];

  logic [15:0] step_exp [4] = '{16'hB400, 16'h5A00, 16'h2D00, 16'h1680};

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Entries are {cycle of out_valid, out_fallback, out}
  task automatic push_both(input logic [EW-1:0] e, input logic [EW-1:0] e4);
    exp_q.push_back(e);
    exp4_q.push_back(e4);
  endtask

  // Scoreboard monitors
  initial begin : mon
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    forever begin
      @(negedge Clk);
      if (out_valid === 1'b1) begin
        n_checks++;
        got = {32'(cyc), out_fallback, out};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL draw_unexpected: got out_valid cycle %0d fb %0b out %0d, expected none",
                   cyc, out_fallback, out);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL draw: got cycle %0d fb %0b out %0d, expected cycle %0d fb %0b out %0d",
                     got[EW-1:OUT_W+1], got[OUT_W], got[OUT_W-1:0],
                     e[EW-1:OUT_W+1], e[OUT_W], e[OUT_W-1:0]);
          end
        end
      end
      if (out_valid_4 === 1'b1) begin
        n_checks++;
        got = {32'(cyc), out_fallback_4, out_4};
        if (exp4_q.size() == 0) begin
          n_fail++;
          $display("FAIL draw4_unexpected: got out_valid cycle %0d fb %0b out %0d, expected none",
                   cyc, out_fallback_4, out_4);
        end else begin
          e = exp4_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL draw4: got cycle %0d fb %0b out %0d, expected cycle %0d fb %0b out %0d",
                     got[EW-1:OUT_W+1], got[OUT_W], got[OUT_W-1:0],
                     e[EW-1:OUT_W+1], e[OUT_W], e[OUT_W-1:0]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Driver / directed sequence
  initial begin : main
    int busy_n;
    int busy4_n;
    int zeros;
    int first_ret;

    reset = 1'b1; enable = 1'b0; seed_load = 1'b0; seed = '0; limit = '0; req = 1'b0;
    tick();
    tick();
    @(negedge Clk);
    check("rst_state", 32'(state_out), 32'hACE1);
    check("rst_out", 32'(out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_fallback", 32'(out_fallback), 32'h0);
    check("rst_seed_fix", 32'(seed_fix), 32'h0);
    check("rst_state4", 32'(state_out_4), 32'hACE1);
    reset = 1'b0;

    // Stepping from seed 0x0001
    tick(); seed_load = 1'b1; seed = 16'h0001;
    tick(); seed_load = 1'b0; enable = 1'b1;
    @(negedge Clk);
    check("seed_loaded", 32'(state_out), 32'h0001);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge Clk);
      check("step", 32'(state_out), 32'(step_exp[i]));
    end
    enable = 1'b0;
    tick();
    @(negedge Clk);
    check("hold", 32'(state_out), 32'h1680);
    check("hold4", 32'(state_out_4), 32'h1680);

    // Zero seed replaced by DEFAULT_SEED
    tick(); seed_load = 1'b1; seed = 16'h0000;
    tick(); seed_load = 1'b0;
    @(negedge Clk);
    check("zero_seed_state", 32'(state_out), 32'hACE1);
    check("seed_fix_pulse", 32'(seed_fix), 32'h1);
    check("seed_fix_pulse4", 32'(seed_fix_4), 32'h1);
    tick();
    @(negedge Clk);
    check("seed_fix_drop", 32'(seed_fix), 32'h0);

    // Full-range draw from 0xB400
    tick(); seed_load = 1'b1; seed = 16'h0001;
    tick(); seed_load = 1'b0; enable = 1'b1;
    tick(); enable = 1'b0;
    @(negedge Clk);
    check("pre_draw_state", 32'(state_out), 32'hB400);
    tick(); req = 1'b1; limit = '0; enable = 1'b1;
    push_both({32'(cyc + 2), 1'b0, 9'd0}, {32'(cyc + 2), 1'b0, 9'd0});
    tick(); req = 1'b0; enable = 1'b0;
    @(negedge Clk);
    check("draw_busy", 32'(busy), 32'h1);
    check("no_step_on_req", 32'(state_out), 32'hB400);
    tick();
    @(negedge Clk);
    check("post_draw_state", 32'(state_out), 32'h5A00);
    check("post_draw_busy", 32'(busy), 32'h0);

    // Rejection sampling from 0x1680, limit 100
    enable = 1'b1;
    tick();
    tick(); enable = 1'b0;
    @(negedge Clk);
    check("pre_reject_state", 32'(state_out), 32'h1680);
    tick(); req = 1'b1; limit = 9'd100;
    push_both({32'(cyc + 8), 1'b0, 9'd90}, {32'(cyc + 5), 1'b1, 9'd0});
    tick(); req = 1'b0;
    busy_n = 0;
    busy4_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (busy) busy_n++;
      if (busy_4) busy4_n++;
      tick();
    end
    @(negedge Clk);
    check("reject_busy_cycles", 32'(busy_n), 32'd7);
    check("fallback_busy_cycles", 32'(busy4_n), 32'd4);
    check("reject_state_after", 32'(state_out), 32'h002D);
    check("fallback_state_after", 32'(state_out_4), 32'h0168);
    check("reject_out_held", 32'(out), 32'd90);
    check("fallback_flag_held", 32'(out_fallback_4), 32'h1);

    // Reset during DRAW
    tick(); seed_load = 1'b1; seed = 16'h1680;
    tick(); seed_load = 1'b0; req = 1'b1; limit = 9'd100;
    tick(); req = 1'b0;
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge Clk);
    check("rstdraw_state", 32'(state_out), 32'hACE1);
    check("rstdraw_out", 32'(out), 32'h0);
    check("rstdraw_busy", 32'(busy), 32'h0);
    check("rstdraw_valid", 32'(out_valid), 32'h0);
    check("rstdraw_fallback4", 32'(out_fallback_4), 32'h0);
    check("rstdraw_busy4", 32'(busy_4), 32'h0);

    // Back-to-back draws, second req in the out_valid cycle
    tick(); seed_load = 1'b1; seed = 16'h0001;
    tick(); seed_load = 1'b0; req = 1'b1; limit = '0;
    push_both({32'(cyc + 2), 1'b0, 9'd1}, {32'(cyc + 2), 1'b0, 9'd1});
    tick(); req = 1'b0;
    tick(); req = 1'b1;
    push_both({32'(cyc + 2), 1'b0, 9'd0}, {32'(cyc + 2), 1'b0, 9'd0});
    tick(); req = 1'b0;
    tick();
    @(negedge Clk);
    check("b2b_state", 32'(state_out), 32'h5A00);

    // seed_load aborts a DRAW
    tick(); seed_load = 1'b1; seed = 16'h1680;
    tick(); seed_load = 1'b0; req = 1'b1; limit = 9'd100;
    tick(); req = 1'b0;
    tick(); seed_load = 1'b1; seed = 16'h0001;
    @(negedge Clk);
    check("abort_busy_before", 32'(busy), 32'h1);
    tick(); seed_load = 1'b0;
    @(negedge Clk);
    check("abort_busy_after", 32'(busy), 32'h0);
    check("abort_busy_after4", 32'(busy_4), 32'h0);
    check("abort_state", 32'(state_out), 32'h0001);
    repeat (8) tick();

    // Full period from 0x0001
    zeros = 0;
    first_ret = 0;
    enable = 1'b1;
    for (int i = 1; i <= 65535; i++) begin
      tick();
      @(negedge Clk);
      if (state_out == 16'h0000) zeros++;
      if (state_out == 16'h0001 && first_ret == 0) first_ret = i;
    end
    enable = 1'b0;
    check("period_length", 32'(first_ret), 32'd65535);
    check("period_no_zero", 32'(zeros), 32'd0);
    check("period_state", 32'(state_out), 32'h0001);
    check("period_state4", 32'(state_out_4), 32'h0001);

    repeat (4) tick();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp4_q_drained", 32'(exp4_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
- Parametrised Galois LFSR random-number generator for game logic: enemy spawn slot, AI direction choice, power-up placement.
- Free-runs on enable; can be reseeded at any time.
- Serves range-limited draws (value < limit) through a req/out_valid handshake, using rejection sampling with a bounded retry count.
- One instance per consumer; replaces fixed-width 9-bit generator usage.

Parameters:
- WIDTH, 16, LFSR state width (>= OUT_W, >= 4).
- OUT_W, 9, width of drawn value and limit.
- TAPS, 16'hB400, Galois feedback mask, WIDTH bits (default maximal-length x^16+x^14+x^13+x^11+1).
- DEFAULT_SEED, 16'hACE1, WIDTH bits, nonzero; used at reset and when a zero seed is loaded.
- MAX_TRIES, 16, rejections allowed per draw before fallback (>= 1).

Ports:
- Clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  advance LFSR one step per cycle while idle.
- seed_load  in  1  load seed this cycle.
- seed  in  WIDTH  seed value.
- limit  in  OUT_W  exclusive upper bound of draw; 0 = full range 2^OUT_W.
- req  in  1  request one draw (sampled only in IDLE).
- busy  out  1  draw in progress (DRAW state).
- out_valid  out  1  one-cycle pulse, out valid.
- out  out  OUT_W  drawn value, held until next out_valid.
- out_fallback  out  1  qualifies out_valid: retry limit hit, out forced to 0.
- seed_fix  out  1  one-cycle pulse: zero seed replaced by DEFAULT_SEED.
- state_out  out  WIDTH  current LFSR state (debug/verification).

Behaviour:
- Reset is synchronous, active-high on Clk.
  - Reset values: state=DEFAULT_SEED; out=0; out_valid=0; out_fallback=0; seed_fix=0; busy=0; FSM=IDLE; try counter=0.
  - Reset mid-DRAW aborts the draw with no out_valid.
- Step function: if state[0]=1, next=(state>>1)^TAPS; else next=state>>1.
- Zero guard: a state of 0 is never retained. If the computed next state would be 0, DEFAULT_SEED is loaded instead.
- Priority each cycle: reset > seed_load > DRAW activity > enable step.
- seed_load:
  - state<=seed, or DEFAULT_SEED if seed==0; in that case seed_fix pulses 1 cycle.
  - Aborts any DRAW: FSM->IDLE, no out_valid.
  - A req in the same cycle is dropped.
- IDLE:
  - enable=1 steps the state; enable=0 holds it.
  - req=1 enters DRAW next cycle and clears the try counter. The state is not stepped on the req cycle, even with enable=1.
- DRAW, each cycle:
  - candidate=state[OUT_W-1:0] (current state, before step).
  - Accept if limit==0 or candidate<limit: out<=candidate, out_fallback<=0, out_valid pulses next cycle. State steps; FSM->IDLE.
  - Reject: counter++. State steps and stays in DRAW.
  - If counter reaches MAX_TRIES on a reject: out<=0, out_fallback<=1, out_valid pulses, FSM->IDLE.
  - State always steps in DRAW regardless of enable.
  - req ignored while busy.
- Latency: req high in cycle N → first evaluation cycle N+1 → earliest out_valid cycle N+2. Each rejection adds 1 cycle. Worst case MAX_TRIES+1 cycles after req.
- busy is high exactly during DRAW cycles.
- out and out_fallback change only with out_valid.
- Back-to-back: req may be asserted in the cycle out_valid is high (FSM already IDLE) and is accepted.

Test Plan:
- Stepping: reset, seed_load 16'h0001, enable=1 for 4 cycles → state_out 16'hB400, 16'h5A00, 16'h2D00, 16'h1680; enable=0 → state holds 16'h1680.
- Zero seed: seed_load with seed=0 → state_out=16'hACE1, seed_fix high exactly 1 cycle.
- Full-range draw: state 16'hB400, limit=0, req in cycle N → out=0, out_valid in N+2, out_fallback=0, state_out=16'h5A00 after.
- Rejection: state 16'h1680, limit=100, req → candidates 128, 320, 416, 208, 360, 180 rejected, then 90 accepted. out=90, out_valid 8 cycles after req, busy high 7 cycles.
- Fallback: same as rejection with MAX_TRIES=4 → out_valid on 4th reject, out=0, out_fallback=1.
- Abort/period:
  - seed_load during DRAW → no out_valid, busy drops next cycle.
  - reset during DRAW → all outputs at reset values.
  - Default params, seed 16'h0001, 65535 enable steps → state returns to 16'h0001, never 0.
